// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous word memory between the instruction
// fetch port (I) and the load/store data port (D).
//   - Per-cycle arbitration. D wins by default. I wins when it is the only
//     requester, or when it has been denied STARVE_MAX cycles in a row.
//   - Tracks which port owns the read data that arrives one cycle after a
//     read grant, so responses go back to the right requester.
//   - Any address with bits above the memory range is still granted, but it
//     never reaches the memory. Reads of such an address return zero with
//     normal timing, and stores to it are dropped.
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   i_req/i_addr -> i_gnt          fetch request and accept
//   i_rvalid/i_rdata               fetch response, one cycle after i_gnt
//   d_req/d_we/d_addr/d_wdata/d_wmask -> d_gnt   data request and accept
//   d_rvalid/d_rdata               load response, one cycle after d_gnt
//   mem_en/mem_we/mem_addr/mem_wdata/mem_wmask  memory command
//   mem_rdata                      memory read data, valid one cycle after a read
module mem_port_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wmask,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } own_e;

  own_e       respOwn_q, respOwn_d;
  logic [3:0] starveCnt_q, starveCnt_d;
  logic       oorFlag_q, oorFlag_d;

  logic iForce;
  logic iGnt;
  logic dGnt;
  logic iOor;
  logic dOor;

  // True when the byte address points past the end of the memory.
  function automatic logic isOutOfRange(input logic [31:0] addr);
    return (addr >> (ADDR_W + 2)) != 32'd0;
  endfunction

  assign iOor = isOutOfRange(i_addr);
  assign dOor = isOutOfRange(d_addr);

  // Grants are suppressed during reset so nothing can reach the memory
  // while resetn is low.
  assign iForce = i_req && (starveCnt_q == STARVE_LIM);
  assign dGnt   = resetn && d_req && !iForce;
  assign iGnt   = resetn && i_req && !dGnt;
  assign i_gnt  = iGnt;
  assign d_gnt  = dGnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      respOwn_q   <= OWN_NONE;
      starveCnt_q <= 4'd0;
      oorFlag_q   <= 1'b0;
    end else begin
      respOwn_q   <= respOwn_d;
      starveCnt_q <= starveCnt_d;
      oorFlag_q   <= oorFlag_d;
    end
  end

  // Memory command and response ownership for the next cycle. The out-of-range
  // flag travels with the owner so that the response is zeroed instead of
  // forwarding whatever stale value the memory still holds.
  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = 32'd0;
    mem_wmask   = 4'd0;
    respOwn_d   = OWN_NONE;
    oorFlag_d   = 1'b0;
    if (dGnt) begin
      mem_en   = !dOor;
      mem_we   = d_we;
      mem_addr = d_addr[ADDR_W+1:2];
      if (d_we) begin
        mem_wdata = d_wdata;
        mem_wmask = d_wmask;
      end else begin
        respOwn_d = OWN_D;
        oorFlag_d = dOor;
      end
    end else if (iGnt) begin
      mem_en    = !iOor;
      mem_addr  = i_addr[ADDR_W+1:2];
      respOwn_d = OWN_I;
      oorFlag_d = iOor;
    end
  end

  // The starvation counter only measures an unbroken run of denied fetches,
  // so one forced grant resets it and D gets default priority again.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!i_req || iGnt) begin
      starveCnt_d = 4'd0;
    end else if (starveCnt_q != STARVE_LIM) begin
      starveCnt_d = starveCnt_q + 4'd1;
    end
  end

  assign i_rvalid = (respOwn_q == OWN_I);
  assign d_rvalid = (respOwn_q == OWN_D);
  assign i_rdata  = (i_rvalid && !oorFlag_q) ? mem_rdata : 32'd0;
  assign d_rdata  = (d_rvalid && !oorFlag_q) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. Holds a behavioural 64x32 memory
// attached to the mem_* port, plus a separate reference image of what the
// memory should contain. Read responses are predicted into per-port queues at
// grant time and compared when the rvalid cycle arrives.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 6;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] memArr [64];
  logic [31:0] refMem [64];
  logic [31:0] iQ [$];
  logic [31:0] dQ [$];

  typedef struct {
    logic        iReq;
    logic        dReq;
    logic        dWe;
    logic [31:0] iAddr;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [3:0]  dWmask;
    logic        expIGnt;
    logic        expDGnt;
    logic        expMemEn;
    logic        expMemWe;
    logic [5:0]  expMemAddr;
    logic [31:0] expWdata;
    logic [3:0]  expWmask;
  } vec_t;

  vec_t vecs [8];

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wmask   (d_wmask),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wmask[b]) memArr[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end else begin
        mem_rdata <= memArr[mem_addr];
      end
    end
  end

  function automatic logic benchOor(input logic [31:0] a);
    return a[31:ADDR_W+2] != '0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic we, input logic [31:0] da,
                               input logic [31:0] wd, input logic [3:0] wm);
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = we;
    d_addr  = da;
    d_wdata = wd;
    d_wmask = wm;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each negedge first retires the response due this cycle, then
  // records predictions for whatever was granted this cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      iQ.delete();
      dQ.delete();
      checkOutput("rst_ctrl", {20'd0, i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we, mem_addr}, 32'd0);
      checkOutput("rst_data", i_rdata | d_rdata | mem_wdata | {28'd0, mem_wmask}, 32'd0);
    end else begin
      checkOutput("sb_i_rvalid", {31'd0, i_rvalid}, {31'd0, iQ.size() > 0});
      if (iQ.size() > 0) checkOutput("sb_i_rdata", i_rdata, iQ.pop_front());
      else               checkOutput("sb_i_rdata_idle", i_rdata, 32'd0);
      checkOutput("sb_d_rvalid", {31'd0, d_rvalid}, {31'd0, dQ.size() > 0});
      if (dQ.size() > 0) checkOutput("sb_d_rdata", d_rdata, dQ.pop_front());
      else               checkOutput("sb_d_rdata_idle", d_rdata, 32'd0);
      if (i_gnt) iQ.push_back(benchOor(i_addr) ? 32'd0 : refMem[i_addr[ADDR_W+1:2]]);
      if (d_gnt) begin
        if (d_we) begin
          if (!benchOor(d_addr)) begin
            for (int b = 0; b < 4; b++) begin
              if (d_wmask[b]) refMem[d_addr[ADDR_W+1:2]][b*8 +: 8] = d_wdata[b*8 +: 8];
            end
          end
        end else begin
          dQ.push_back(benchOor(d_addr) ? 32'd0 : refMem[d_addr[ADDR_W+1:2]]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < 64; k++) begin
      memArr[k] = 32'd0;
      refMem[k] = 32'd0;
    end
    memArr[2] = 32'h0050_0093;
    refMem[2] = 32'h0050_0093;
    mem_rdata = 32'd0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  32'h0,         4'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h8,   32'h0,  32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd2,  32'h0,         4'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h10, 32'h0,         4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd4,  32'h0,         4'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h8,   32'h14, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 6'd5,  32'h0,         4'h0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h3C, 32'hCAFE_F00D, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 6'd15, 32'hCAFE_F00D, 4'h5};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,  32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  32'h0,         4'h0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h13, 32'h0,         4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd4,  32'h0,         4'h0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'hFC,  32'h0,  32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd63, 32'h0,         4'h0};

    // Reset with both ports requesting: nothing may be granted.
    resetn = 1'b0;
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b1, 32'h10, 32'h1234_5678, 4'hF);
    @(negedge clk);
    checkOutput("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
    checkOutput("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    nextCycle();
    nextCycle();
    idle();
    resetn = 1'b1;
    nextCycle();

    // Fetch only, three back-to-back grants of word 2.
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("fetch%0d_i_gnt", c), {31'd0, i_gnt}, 32'd1);
      checkOutput($sformatf("fetch%0d_mem_en", c), {31'd0, mem_en}, 32'd1);
      checkOutput($sformatf("fetch%0d_mem_addr", c), {26'd0, mem_addr}, 32'd2);
      if (c > 0) checkOutput($sformatf("fetch%0d_i_rdata", c), i_rdata, 32'h0050_0093);
      nextCycle();
    end
    idle();
    @(negedge clk);
    checkOutput("fetch_last_i_rdata", i_rdata, 32'h0050_0093);
    nextCycle();

    // Table of single-cycle vectors, each followed by an idle cycle so the
    // starvation counter starts from zero.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(vecs[k].iReq, vecs[k].iAddr, vecs[k].dReq, vecs[k].dWe,
                    vecs[k].dAddr, vecs[k].dWdata, vecs[k].dWmask);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_i_gnt", k), {31'd0, i_gnt}, {31'd0, vecs[k].expIGnt});
      checkOutput($sformatf("vec%0d_d_gnt", k), {31'd0, d_gnt}, {31'd0, vecs[k].expDGnt});
      checkOutput($sformatf("vec%0d_mem_en", k), {31'd0, mem_en}, {31'd0, vecs[k].expMemEn});
      checkOutput($sformatf("vec%0d_mem_we", k), {31'd0, mem_we}, {31'd0, vecs[k].expMemWe});
      checkOutput($sformatf("vec%0d_mem_addr", k), {26'd0, mem_addr}, {26'd0, vecs[k].expMemAddr});
      checkOutput($sformatf("vec%0d_mem_wdata", k), mem_wdata, vecs[k].expWdata);
      checkOutput($sformatf("vec%0d_mem_wmask", k), {28'd0, mem_wmask}, {28'd0, vecs[k].expWmask});
      nextCycle();
      idle();
      nextCycle();
    end

    // Contention: D load wins, I is served once D drops its request.
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
    @(negedge clk);
    checkOutput("cont_d_gnt", {31'd0, d_gnt}, 32'd1);
    checkOutput("cont_i_gnt", {31'd0, i_gnt}, 32'd0);
    checkOutput("cont_mem_addr", {26'd0, mem_addr}, 32'd4);
    nextCycle();
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    checkOutput("cont_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    checkOutput("cont_i_gnt2", {31'd0, i_gnt}, 32'd1);
    nextCycle();
    idle();
    nextCycle();

    // Starvation: D holds loads, I gets exactly one forced grant on cycle 5.
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checkOutput($sformatf("starve%0d_i_gnt", c), {31'd0, i_gnt}, {31'd0, c == 4});
      checkOutput($sformatf("starve%0d_d_gnt", c), {31'd0, d_gnt}, {31'd0, c != 4});
      nextCycle();
    end
    idle();
    nextCycle();

    // Full store, then partial store, each read back through D.
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h3C, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    checkOutput("store_mem_we", {31'd0, mem_we}, 32'd1);
    checkOutput("store_mem_addr", {26'd0, mem_addr}, 32'd15);
    checkOutput("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h3C, 32'd0, 4'd0);
    @(negedge clk);
    checkOutput("store_no_rvalid", {31'd0, d_rvalid}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h3C, 32'h1122_3344, 4'h3);
    @(negedge clk);
    checkOutput("load_after_store", d_rdata, 32'hDEAD_BEEF);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h3C, 32'd0, 4'd0);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("partial_store_load", d_rdata, 32'hDEAD_3344);
    nextCycle();

    // Out of range: fetch after a real read so mem_rdata holds stale data,
    // then a store that must not touch word 0.
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    nextCycle();
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    checkOutput("oor_i_gnt", {31'd0, i_gnt}, 32'd1);
    checkOutput("oor_mem_en", {31'd0, mem_en}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h100, 32'h1234_5678, 4'hF);
    @(negedge clk);
    checkOutput("oor_i_rvalid", {31'd0, i_rvalid}, 32'd1);
    checkOutput("oor_i_rdata", i_rdata, 32'd0);
    checkOutput("oor_store_mem_en", {31'd0, mem_en}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h0, 32'd0, 4'd0);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("oor_store_dropped", d_rdata, 32'd0);
    nextCycle();

    // Reset between a load grant and its response edge.
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h3C, 32'd0, 4'd0);
    @(negedge clk);
    checkOutput("midrst_d_gnt", {31'd0, d_gnt}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("midrst_d_gnt_low", {31'd0, d_gnt}, 32'd0);
    checkOutput("midrst_mem_en_low", {31'd0, mem_en}, 32'd0);
    checkOutput("midrst_mem_addr_low", {26'd0, mem_addr}, 32'd0);
    idle();
    nextCycle();
    nextCycle();
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("midrst%0d_d_rvalid", c), {31'd0, d_rvalid}, 32'd0);
      nextCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single-port word memory (64 x 32 by default) between two requesters: the instruction-fetch port (I) and the load/store data port (D).
- Performs per-cycle arbitration, tracks response ownership for the 1-cycle synchronous read latency, and applies a starvation guard so fetch cannot be locked out by back-to-back loads/stores.
- Sits between the core's fetch/LSU logic and the memory array.

Parameters:
- ADDR_W, 6, memory word-address width (depth = 2**ADDR_W words).
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch gets forced priority; legal range 1..15.

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  32  fetch byte address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  32  fetch data
- d_req  in  1  data request; held with d_* until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_wmask  in  4  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid (loads only)
- d_rdata  out  32  load data
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  32  memory write data
- mem_wmask  out  4  memory byte enables
- mem_rdata  in  32  memory read data; valid the cycle after mem_en && !mem_we

Behaviour:
- Grant (combinational from current inputs and state): at most one of i_gnt/d_gnt per cycle.
  - Default: D wins.
  - If starve_cnt == STARVE_MAX and i_req, I wins.
  - Single requester always wins.
- Memory drive:
  - Granted request drives mem_en = 1, mem_addr = addr[ADDR_W+1:2].
  - mem_we = d_we only when D is granted; I is read-only.
  - mem_wdata/mem_wmask pass d_wdata/d_wmask on D store, otherwise 0.
  - No grant -> mem_en = 0, mem_we = 0.
- Out-of-range: addr[31:ADDR_W+2] != 0 -> still granted, but mem_en = 0. A load/fetch returns rdata = 0 with the normal rvalid timing; a store is dropped. addr[1:0] is ignored (word-aligned only).
- Response owner register resp_own in {NONE, I, D} (FSM):
  - On a load/fetch grant, the next state is I or D; otherwise NONE.
  - In state I: i_rvalid = 1, i_rdata = mem_rdata (0 if out-of-range flag set).
  - In state D: d_rvalid = 1, d_rdata likewise.
  - A new grant in the same cycle as a response is legal: full 1-per-cycle throughput.
- Stores produce no rvalid; d_gnt is the completion.
- rdata outputs are 0 whenever the matching rvalid is 0.
- starve_cnt (4-bit):
  - Increments when i_req && !i_gnt, saturating at STARVE_MAX.
  - Clears to 0 on i_gnt or when !i_req.
  - Forced fetch priority therefore lasts exactly one grant.
- Reset (asynchronous, any cycle):
  - resp_own = NONE, starve_cnt = 0, out-of-range flag = 0.
  - All outputs 0: i_gnt, d_gnt, rvalids, rdata, mem_* (no grants while resetn = 0).
  - A response pending at reset is discarded; no rvalid after deassertion until a new grant.
- Requesters must keep req/addr stable until gnt; dropping req before gnt is allowed and simply cancels.

Test Plan:
- Fetch only: i_req = 1, i_addr = 0x8 for 3 cycles, mem word2 = 0x00500093 -> i_gnt every cycle, mem_addr = 2, i_rvalid one cycle after each grant with i_rdata = 0x00500093.
- Contention: i_req = d_req = 1 (load 0x10) -> d_gnt first, mem_addr = 4; d_rvalid next cycle; i_gnt only once d_req drops.
- Starvation, STARVE_MAX = 4: i_req held, d_req held with loads -> d_gnt for 4 cycles, then i_gnt on cycle 5, then D wins again with starve_cnt = 0.
- Store: d_we = 1, d_addr = 0x3C, d_wdata = 0xDEADBEEF, d_wmask = 0xF -> mem_we = 1, mem_addr = 15, no d_rvalid; a following load of 0x3C returns 0xDEADBEEF.
- Out-of-range: fetch 0x100 with ADDR_W = 6 -> i_gnt = 1, mem_en = 0, i_rvalid next cycle with i_rdata = 0; store to 0x100 leaves memory unchanged.
- Reset mid-op: grant a load, assert resetn = 0 before the response edge -> all outputs 0 immediately; after release, d_rvalid stays 0 until a new request.
